axis_reg_slice_pipe: RTL and testbench
======================================

// Module: axis_reg_slice_pipe
// PURPOSE
//  Parametrised AXI4-Stream register slice: a chain of STAGES identical slices for
//  timing closure on long stream paths. It carries TDATA/TKEEP/TLAST/TUSER and can run
//  as a full skid buffer, a forward-only register or a bypass. An occupancy counter
//  supports debug and flow monitoring. It sits between any AXIS master and slave,
//  with lossless, in-order transfer.
// PARAMETERS
//  DATA_WIDTH  32  TDATA bits; must be a multiple of 8
//  USER_WIDTH  1   TUSER bits; must be >= 1
//  STAGES      1   number of cascaded slices; must be >= 1
//  MODE        0   0 = full skid (registered tready), 1 = forward-only (comb tready),
//                  2 = bypass (wires only)
//  local OCC_W = $clog2(2*STAGES+1)
// PORTS
//  clk            in   1             rising-edge clock
//  reset_n        in   1             asynchronous, active-low reset
//  s_axis_tvalid  in   1             upstream beat valid
//  s_axis_tready  out  1             slice can accept a beat
//  s_axis_tdata   in   DATA_WIDTH    upstream data
//  s_axis_tkeep   in   DATA_WIDTH/8  byte qualifiers
//  s_axis_tlast   in   1             packet end
//  s_axis_tuser   in   USER_WIDTH    sideband
//  m_axis_tvalid  out  1             downstream beat valid
//  m_axis_tready  in   1             downstream accepts
//  m_axis_tdata   out  DATA_WIDTH    downstream data
//  m_axis_tkeep   out  DATA_WIDTH/8  downstream byte qualifiers
//  m_axis_tlast   out  1             downstream packet end
//  m_axis_tuser   out  USER_WIDTH    downstream sideband
//  occupancy      out  OCC_W         beats currently held in the chain
// BEHAVIOUR
//  - Transfer rules: a beat moves when tvalid && tready on a rising edge.
//    - TDATA, TKEEP, TLAST and TUSER travel as one word; beats are never dropped,
//      duplicated or reordered.
//    - Once m_axis_tvalid is asserted, it and the output payload hold until accepted.
//  - Reset (reset_n low, async):
//    - all valid/skid flags, occupancy and s_axis_tready go to 0; payload regs go to 0;
//    - m_axis_tvalid = 0 while reset is held.
//    - MODE 0: s_axis_tready goes to 1 on the first clk edge after reset_n rises.
//    - MODE 1: s_axis_tready goes to 1 immediately after reset_n rises.
//    - A reset mid-stream discards all held beats; no stale beat may emerge afterwards.
//  - MODE 0, per-stage FSM over main reg + skid reg:
//    - EMPTY: accept -> BUSY.
//    - BUSY: in only -> FULL; out only -> EMPTY; in & out -> BUSY (main reloads).
//    - FULL: out -> BUSY (skid moves to main, skid cleared); no out -> stay FULL.
//    - Stage ready is a register = (next state != FULL); no combinational path from
//      m_axis_tready to s_axis_tready.
//    - Latency: STAGES cycles from accept to m_axis_tvalid.
//    - Throughput: 1 beat/cycle sustained. Capacity: 2*STAGES beats.
//  - MODE 1, per stage: one register.
//    - Stage ready = !valid || downstream ready (combinational through the chain).
//    - Latency: STAGES cycles. Capacity: STAGES beats. Throughput: 1/cycle.
//  - MODE 2: m_* = s_*, s_axis_tready = m_axis_tready, occupancy = 0; latency 0.
//  - occupancy: registered count that tracks the beats held; it reflects the state after
//    each edge.
//    - +1 on s-side accept, -1 on m-side accept, unchanged when both happen together.
//    - Never exceeds 2*STAGES (MODE 0) or STAGES (MODE 1); never wraps.
//  - tready with tvalid low: no effect. s_axis_tvalid while s_axis_tready = 0: ignored,
//    and the upstream must hold its beat.
// TESTING
//  1 Reset: reset_n=0 with tvalid=1 -> m_axis_tvalid=0, s_axis_tready=0, occupancy=0;
//    release -> s_axis_tready=1 within 1 edge (MODE 0).
//  2 Stream, STAGES=2, m_ready=1, beats 0x0..0xF back-to-back -> first output
//    2 cycles after first accept, 16 consecutive outputs 0x0..0xF, no bubbles.
//  3 Backpressure, STAGES=2, MODE 0, m_ready=0, continuous valid -> exactly 4 beats
//    accepted, occupancy=4, s_axis_tready=0; then m_ready=1 -> 4 drain in order and
//    s_axis_tready returns to 1.
//  4 Random valid/ready (50%/50%), 1000 beats, tlast every 8th, random tkeep/tuser
//    -> scoreboard exact match; occupancy equals the model count every cycle.
//  5 Mid-stream reset at occupancy=3 -> all outputs 0 asynchronously; after release,
//    only new beats appear.
//  6 MODE 1 (STAGES=3): capacity 3 and latency 3. MODE 2: zero latency, and
//    s_axis_tready equals m_axis_tready.

Source files
------------

// File: rtl/axis_reg_slice_pipe.sv
// AXI4-Stream register slice chain: STAGES cascaded skid / forward-only slices or a
// pure bypass, with a beat-occupancy counter for flow monitoring.

module axis_reg_slice_stage #(
  parameter int W    = 8,
  parameter int MODE = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  input  logic [W-1:0] s_data_i,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic [W-1:0] m_data_o
);
  if (MODE == 0) begin : g_skid
    typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;
    state_t         state_q, state_d;
    logic           rdy_q;
    logic [W-1:0]   main_q, main_d, skid_q, skid_d;
    logic           in_hs, out_hs;

    assign in_hs  = s_valid_i & rdy_q;
    assign out_hs = (state_q != EMPTY) & m_ready_i;

    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
        EMPTY: if (in_hs) begin
          main_d  = s_data_i;
          state_d = BUSY;
        end
        BUSY: begin
          if (in_hs && !out_hs) begin
            skid_d  = s_data_i;
            state_d = FULL;
          end else if (!in_hs && out_hs) begin
            state_d = EMPTY;
          end else if (in_hs && out_hs) begin
            main_d  = s_data_i;
          end
        end
        FULL: if (out_hs) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
        default: state_d = EMPTY;
      endcase
    end

    // Ready is registered from the next state, so m_ready never reaches s_ready combinationally.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= EMPTY;
        rdy_q   <= 1'b0;
        main_q  <= '0;
        skid_q  <= '0;
      end else begin
        state_q <= state_d;
        rdy_q   <= (state_d != FULL);
        main_q  <= main_d;
        skid_q  <= skid_d;
      end
    end

    assign s_ready_o = rdy_q;
    assign m_valid_o = (state_q != EMPTY);
    assign m_data_o  = main_q;
  end else begin : g_fwd
    logic         vld_q;
    logic [W-1:0] data_q;

    assign s_ready_o = !vld_q || m_ready_i;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        vld_q  <= 1'b0;
        data_q <= '0;
      end else if (s_ready_o) begin
        vld_q <= s_valid_i;
        if (s_valid_i) data_q <= s_data_i;
      end
    end

    assign m_valid_o = vld_q;
    assign m_data_o  = data_q;
  end
endmodule

module axis_reg_slice_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 1,
  parameter int STAGES     = 1,
  parameter int MODE       = 0,
  localparam int OCC_W     = $clog2(2*STAGES+1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tlast,
  input  logic [USER_WIDTH-1:0]   s_axis_tuser,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic [USER_WIDTH-1:0]   m_axis_tuser,
  output logic [OCC_W-1:0]        occupancy
);
  localparam int KW = DATA_WIDTH / 8;
  localparam int W  = DATA_WIDTH + KW + 1 + USER_WIDTH;

  if (MODE == 2) begin : g_bypass
    // Bypass still honours reset: nothing is presented or accepted while reset is held.
    assign m_axis_tvalid = s_axis_tvalid & reset_n;
    assign s_axis_tready = m_axis_tready & reset_n;
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tkeep  = s_axis_tkeep;
    assign m_axis_tlast  = s_axis_tlast;
    assign m_axis_tuser  = s_axis_tuser;
    assign occupancy     = '0;
  end else begin : g_chain
    logic [STAGES:0]        vld;
    logic [STAGES:0]        rdy;
    logic [STAGES:0][W-1:0] dat;
    logic                   s_hs, m_hs;
    logic [OCC_W-1:0]       occ_q, occ_d;

    assign vld[0]      = s_axis_tvalid;
    assign dat[0]      = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser};
    assign rdy[STAGES] = m_axis_tready;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
      axis_reg_slice_stage #(.W(W), .MODE(MODE)) u_stage (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_valid_i (vld[i]),
        .s_ready_o (rdy[i]),
        .s_data_i  (dat[i]),
        .m_valid_o (vld[i+1]),
        .m_ready_i (rdy[i+1]),
        .m_data_o  (dat[i+1])
      );
    end

    assign s_axis_tready = rdy[0] & reset_n;
    assign m_axis_tvalid = vld[STAGES];
    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} = dat[STAGES];

    assign s_hs = s_axis_tvalid & s_axis_tready;
    assign m_hs = m_axis_tvalid & m_axis_tready;

    always_comb begin
      occ_d = occ_q;
      if (s_hs && !m_hs)      occ_d = occ_q + 1'b1;
      else if (!s_hs && m_hs) occ_d = occ_q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) occ_q <= '0;
      else          occ_q <= occ_d;
    end

    assign occupancy = occ_q;
  end
endmodule

// File: tb/tb_axis_reg_slice_pipe.sv
// Bench: skid chain (MODE 0, 2 stages), forward chain (MODE 1, 3 stages) and bypass,
// each checked every cycle against a queue model of the beats held.

module tb_axis_reg_slice_pipe;
  typedef logic [38:0] beat_t;   // {tdata[31:0], tkeep[3:0], tlast, tuser[1:0]}
  typedef struct { int cyc; beat_t d; } obs_t;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [2:0]      sv = '0, mr = '0;
  logic [2:0][38:0] sd = '0;
  wire  [2:0]      sr, mv;
  wire  [2:0][38:0] md;
  wire  [2:0]      occ0, occ1;
  wire  [1:0]      occ2;

  int    checks = 0, errors = 0, cyc = 0;
  bit    acc [3];
  int    tin [3][$];
  obs_t  tout [3][$];
  beat_t mq [2][$];
  bit    stall_q [2];
  beat_t stall_d [2];

  always #5 clk = ~clk;

  axis_reg_slice_pipe #(.DATA_WIDTH(32), .USER_WIDTH(2), .STAGES(2), .MODE(0)) u0 (
    .clk(clk), .reset_n(reset_n),
    .s_axis_tvalid(sv[0]), .s_axis_tready(sr[0]), .s_axis_tdata(sd[0][38:7]),
    .s_axis_tkeep(sd[0][6:3]), .s_axis_tlast(sd[0][2]), .s_axis_tuser(sd[0][1:0]),
    .m_axis_tvalid(mv[0]), .m_axis_tready(mr[0]), .m_axis_tdata(md[0][38:7]),
    .m_axis_tkeep(md[0][6:3]), .m_axis_tlast(md[0][2]), .m_axis_tuser(md[0][1:0]),
    .occupancy(occ0));

  axis_reg_slice_pipe #(.DATA_WIDTH(32), .USER_WIDTH(2), .STAGES(3), .MODE(1)) u1 (
    .clk(clk), .reset_n(reset_n),
    .s_axis_tvalid(sv[1]), .s_axis_tready(sr[1]), .s_axis_tdata(sd[1][38:7]),
    .s_axis_tkeep(sd[1][6:3]), .s_axis_tlast(sd[1][2]), .s_axis_tuser(sd[1][1:0]),
    .m_axis_tvalid(mv[1]), .m_axis_tready(mr[1]), .m_axis_tdata(md[1][38:7]),
    .m_axis_tkeep(md[1][6:3]), .m_axis_tlast(md[1][2]), .m_axis_tuser(md[1][1:0]),
    .occupancy(occ1));

  axis_reg_slice_pipe #(.DATA_WIDTH(32), .USER_WIDTH(2), .STAGES(1), .MODE(2)) u2 (
    .clk(clk), .reset_n(reset_n),
    .s_axis_tvalid(sv[2]), .s_axis_tready(sr[2]), .s_axis_tdata(sd[2][38:7]),
    .s_axis_tkeep(sd[2][6:3]), .s_axis_tlast(sd[2][2]), .s_axis_tuser(sd[2][1:0]),
    .m_axis_tvalid(mv[2]), .m_axis_tready(mr[2]), .m_axis_tdata(md[2][38:7]),
    .m_axis_tkeep(md[2][6:3]), .m_axis_tlast(md[2][2]), .m_axis_tuser(md[2][1:0]),
    .occupancy(occ2));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int occ_of(input int k);
    return (k == 0) ? int'(occ0) : int'(occ1);
  endfunction

  function automatic beat_t mkbeat(input int i, input bit rnd);
    beat_t b;
    b[38:7] = rnd ? 32'($urandom) : 32'(i);
    b[6:3]  = rnd ? 4'($urandom) : 4'hF;
    b[2]    = (i % 8 == 7);
    b[1:0]  = rnd ? 2'($urandom) : 2'(i);
    return b;
  endfunction

  // Reference: every beat accepted upstream must leave downstream in order; the model
  // count is the occupancy; a stalled output must hold.
  always @(negedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) begin
        mq[k].delete();
        stall_q[k] = 1'b0;
        chk("rst_mvalid", 64'(mv[k]), 64'(0));
        chk("rst_sready", 64'(sr[k]), 64'(0));
        chk("rst_occ", 64'(occ_of(k)), 64'(0));
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        chk("occ_model", 64'(occ_of(k)), 64'(mq[k].size()));
        if (stall_q[k]) begin
          chk("hold_valid", 64'(mv[k]), 64'(1));
          chk("hold_data", 64'(md[k]), 64'(stall_d[k]));
        end
        if (mv[k]) begin
          chk("beat_present", 64'(mq[k].size() != 0), 64'(1));
          if (mq[k].size() != 0) chk("beat_order", 64'(md[k]), 64'(mq[k][0]));
        end
        stall_q[k] = mv[k] && !mr[k];
        stall_d[k] = md[k];
        if (mv[k] && mr[k] && mq[k].size() != 0) void'(mq[k].pop_front());
        if (sv[k] && sr[k]) mq[k].push_back(sd[k]);
      end
      chk("byp_valid", 64'(mv[2]), 64'(sv[2]));
      chk("byp_ready", 64'(sr[2]), 64'(mr[2]));
      chk("byp_occ", 64'(occ2), 64'(0));
      if (sv[2]) chk("byp_data", 64'(md[2]), 64'(sd[2]));
    end
  end

  task automatic tick();
    obs_t o;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      acc[k] = sv[k] && sr[k];
      if (acc[k]) tin[k].push_back(cyc);
      if (mv[k] && mr[k]) begin
        o.cyc = cyc;
        o.d   = md[k];
        tout[k].push_back(o);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input int k, input int n, input int base, input int vpct,
                      input int rpct, input bit rnd);
    int sent = 0, guard = 0;
    sv[k] = 1'b0;
    while (sent < n && guard < 20000) begin
      if (!sv[k] && $urandom_range(99) < vpct) begin
        sv[k] = 1'b1;
        sd[k] = mkbeat(base + sent, rnd);
      end
      if (rpct >= 0) mr[k] = ($urandom_range(99) < rpct);
      tick();
      guard++;
      if (acc[k]) begin
        sent++;
        sv[k] = 1'b0;
      end
    end
    sv[k] = 1'b0;
    chk("send_done", 64'(sent), 64'(n));
  endtask

  task automatic drain(input int k);
    int g = 0;
    mr[k] = 1'b1;
    while (mq[k].size() != 0 && g < 100) begin
      tick();
      g++;
    end
    tick();
    chk("drain_empty", 64'(mq[k].size()), 64'(0));
  endtask

  task automatic push_held(input int k);
    int g = 0;
    while (!acc[k] && g < 50) begin
      tick();
      g++;
    end
    sv[k] = 1'b0;
    chk("held_beat_taken", 64'(acc[k]), 64'(1));
  endtask

  initial begin
    int nlast;
    // reset with valid asserted upstream
    sv = 3'b111;
    sd[0] = mkbeat(99, 0);
    sd[1] = mkbeat(98, 0);
    repeat (3) tick();
    chk("rst_m0_valid", 64'(mv[0]), 64'(0));
    chk("rst_m0_ready", 64'(sr[0]), 64'(0));
    chk("rst_m0_occ", 64'(occ0), 64'(0));
    reset_n = 1'b1;
    #1;
    chk("m1_ready_on_release", 64'(sr[1]), 64'(1));
    chk("m0_ready_before_edge", 64'(sr[0]), 64'(0));
    sv = '0;
    tick();
    chk("m0_ready_after_edge", 64'(sr[0]), 64'(1));

    // back-to-back stream 0x0..0xF
    tin[0].delete(); tout[0].delete();
    mr[0] = 1'b1;
    send(0, 16, 0, 100, -1, 0);
    drain(0);
    chk("stream_count", 64'(tout[0].size()), 64'(16));
    chk("stream_in_b2b", 64'(tin[0][15] - tin[0][0]), 64'(15));
    chk("stream_latency", 64'(tout[0][0].cyc - tin[0][0]), 64'(2));
    for (int i = 0; i < tout[0].size() && i < 16; i++) begin
      chk("stream_data", 64'(tout[0][i].d[38:7]), 64'(i));
      chk("stream_no_bubble", 64'(tout[0][i].cyc - tout[0][0].cyc), 64'(i));
    end

    // backpressure: capacity 4, then ordered drain
    tin[0].delete(); tout[0].delete();
    mr[0] = 1'b0;
    send(0, 4, 256, 100, -1, 0);
    sv[0] = 1'b1;
    sd[0] = mkbeat(260, 0);
    repeat (6) tick();
    chk("bp_accepted", 64'(tin[0].size()), 64'(4));
    chk("bp_occ", 64'(occ0), 64'(4));
    chk("bp_sready", 64'(sr[0]), 64'(0));
    chk("bp_mvalid", 64'(mv[0]), 64'(1));
    chk("bp_head", 64'(md[0][38:7]), 64'(256));
    mr[0] = 1'b1;
    push_held(0);
    drain(0);
    chk("bp_sready_back", 64'(sr[0]), 64'(1));
    chk("bp_out_count", 64'(tout[0].size()), 64'(5));
    for (int i = 0; i < tout[0].size() && i < 5; i++)
      chk("bp_drain_order", 64'(tout[0][i].d[38:7]), 64'(256 + i));

    // random valid/ready
    tout[0].delete();
    send(0, 1000, 4096, 50, 50, 1);
    drain(0);
    chk("rand_count", 64'(tout[0].size()), 64'(1000));
    nlast = 0;
    foreach (tout[0][i]) nlast += int'(tout[0][i].d[2]);
    chk("rand_tlast_count", 64'(nlast), 64'(125));
    send(1, 300, 0, 50, 50, 1);
    drain(1);

    // mid-stream reset with 3 beats held
    mr[0] = 1'b0;
    send(0, 3, 512, 100, -1, 0);
    chk("mid_occ", 64'(occ0), 64'(3));
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_mvalid", 64'(mv[0]), 64'(0));
    chk("mid_rst_sready", 64'(sr[0]), 64'(0));
    chk("mid_rst_occ", 64'(occ0), 64'(0));
    chk("mid_rst_data", 64'(md[0]), 64'(0));
    tick(); tick();
    reset_n = 1'b1;
    #1;
    chk("mid_rel_m0_ready", 64'(sr[0]), 64'(0));
    chk("mid_rel_m1_ready", 64'(sr[1]), 64'(1));
    tout[0].delete();
    mr[0] = 1'b1;
    send(0, 4, 768, 100, -1, 0);
    drain(0);
    chk("post_rst_count", 64'(tout[0].size()), 64'(4));
    if (tout[0].size() != 0) chk("post_rst_first", 64'(tout[0][0].d[38:7]), 64'(768));

    // MODE 1: capacity 3, comb ready, latency 3
    tin[1].delete(); tout[1].delete();
    mr[1] = 1'b0;
    send(1, 3, 1024, 100, -1, 0);
    sv[1] = 1'b1;
    sd[1] = mkbeat(1027, 0);
    repeat (4) tick();
    chk("m1_capacity", 64'(tin[1].size()), 64'(3));
    chk("m1_occ", 64'(occ1), 64'(3));
    chk("m1_sready_full", 64'(sr[1]), 64'(0));
    mr[1] = 1'b1;
    #1;
    chk("m1_comb_ready", 64'(sr[1]), 64'(1));
    push_held(1);
    drain(1);
    tin[1].delete(); tout[1].delete();
    send(1, 1, 2048, 100, -1, 0);
    drain(1);
    chk("m1_latency", 64'(tout[1].size() ? tout[1][0].cyc - tin[1][0] : -1), 64'(3));

    // MODE 2: wires only
    mr[2] = 1'b0;
    sv[2] = 1'b1;
    sd[2] = {32'hCAFE_F00D, 4'h5, 1'b1, 2'h2};
    #1;
    chk("byp_ready_lo", 64'(sr[2]), 64'(0));
    chk("byp_zero_lat", 64'(md[2][38:7]), 64'(32'hCAFE_F00D));
    chk("byp_valid_lit", 64'(mv[2]), 64'(1));
    mr[2] = 1'b1;
    #1;
    chk("byp_ready_hi", 64'(sr[2]), 64'(1));
    tick();
    sv[2] = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
